// File: rtl/mem_access_stage_if.sv
// Execute-to-memory-stage bus and write-back result bundle.
// master drives the execute-side fields, slave is the memory stage.
interface mem_access_stage_if;
    logic        in_valid;
    logic        memRead;
    logic        memWrite;
    logic        branch;
    logic        regWrite;
    logic        memToReg;
    logic [31:0] alures;
    logic [31:0] readData2;
    logic        aluZero;
    logic [31:0] addres;
    logic [4:0]  instruction;
    logic        stall;
    logic        pcSrc;
    logic [31:0] branchTarget;
    logic        wb_valid;
    logic        wb_regWrite;
    logic        wb_memToReg;
    logic [31:0] wb_readData;
    logic [31:0] wb_aluResult;
    logic [4:0]  wb_writeReg;
    logic        misaligned;

    modport master (
        output in_valid, memRead, memWrite, branch, regWrite, memToReg,
        output alures, readData2, aluZero, addres, instruction,
        input  stall, pcSrc, branchTarget, wb_valid, wb_regWrite,
        input  wb_memToReg, wb_readData, wb_aluResult, wb_writeReg,
        input  misaligned
    );

    modport slave (
        input  in_valid, memRead, memWrite, branch, regWrite, memToReg,
        input  alures, readData2, aluZero, addres, instruction,
        output stall, pcSrc, branchTarget, wb_valid, wb_regWrite,
        output wb_memToReg, wb_readData, wb_aluResult, wb_writeReg,
        output misaligned
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: multi-cycle word load/store, branch
// resolution and registered write-back bundle.
module mem_access_stage #(
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 2
) (
    input logic                clk,
    input logic                rst,
    mem_access_stage_if.slave  bus
);
    localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] mem_q [2**ADDR_W];

    logic              mem_op;
    logic              at_last;
    logic              done;
    logic              mis;
    logic              do_store;
    logic              do_load;
    logic [ADDR_W-1:0] idx;
    logic              unused_hi;

    logic        pcSrc_q;
    logic [31:0] branchTarget_q;
    logic        wb_valid_q;
    logic        wb_regWrite_q;
    logic        wb_memToReg_q;
    logic [31:0] wb_readData_q;
    logic [31:0] wb_aluResult_q;
    logic [4:0]  wb_writeReg_q;
    logic        misaligned_q;

    assign unused_hi = ^bus.alures[31:ADDR_W+2];

    always_comb begin
        idx      = bus.alures[ADDR_W+1:2];
        mem_op   = bus.in_valid & (bus.memRead | bus.memWrite);
        // cnt only reaches a nonzero LAST while BUSY
        at_last  = (cnt_q == LAST) & ((LAST == 4'd0) | (state_q == BUSY));
        done     = bus.in_valid & (~mem_op | at_last);
        mis      = mem_op & (bus.alures[1:0] != 2'b00);
        do_store = done & mem_op & bus.memWrite & ~mis;
        do_load  = done & mem_op & bus.memRead & ~bus.memWrite & ~mis;
        cnt_d    = (mem_op & ~at_last) ? cnt_q + 4'd1 : 4'd0;
        state_d  = (cnt_d != 4'd0) ? BUSY : IDLE;
    end

    assign bus.stall = mem_op & ~at_last;

    always_ff @(posedge clk) begin
        if (!rst && do_store) begin
            mem_q[idx] <= bus.readData2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            pcSrc_q        <= 1'b0;
            branchTarget_q <= 32'd0;
            wb_valid_q     <= 1'b0;
            wb_regWrite_q  <= 1'b0;
            wb_memToReg_q  <= 1'b0;
            wb_readData_q  <= 32'd0;
            wb_aluResult_q <= 32'd0;
            wb_writeReg_q  <= 5'd0;
            misaligned_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wb_valid_q   <= done;
            pcSrc_q      <= done & bus.branch & bus.aluZero;
            misaligned_q <= done & mis;
            if (done) begin
                branchTarget_q <= bus.addres;
                wb_regWrite_q  <= bus.regWrite;
                wb_memToReg_q  <= bus.memToReg;
                wb_aluResult_q <= bus.alures;
                wb_writeReg_q  <= bus.instruction;
                // read-before-write: load sees the pre-edge contents
                wb_readData_q  <= do_load ? mem_q[idx] : 32'd0;
            end
        end
    end

    assign bus.pcSrc        = pcSrc_q;
    assign bus.branchTarget = branchTarget_q;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_regWrite  = wb_regWrite_q;
    assign bus.wb_memToReg  = wb_memToReg_q;
    assign bus.wb_readData  = wb_readData_q;
    assign bus.wb_aluResult = wb_aluResult_q;
    assign bus.wb_writeReg  = wb_writeReg_q;
    assign bus.misaligned   = misaligned_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed and random ops on a MEM_LAT=2
// instance plus a reset-abort scenario on a MEM_LAT=4 instance.
module tb_mem_access_stage;
    typedef struct packed {
        bit        v;
        bit        rd;
        bit        wr;
        bit        br;
        bit        rw;
        bit        m2r;
        bit        z;
        bit [31:0] alu;
        bit [31:0] wd;
        bit [31:0] tgt;
        bit [4:0]  dst;
    } op_t;

    typedef struct packed {
        logic        stall;
        logic        pc;
        logic [31:0] tgt;
        logic        v;
        logic        rw;
        logic        m2r;
        logic [31:0] rdat;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic        mis;
    } out_t;

    logic clk = 1'b0;
    logic rst2 = 1'b1;
    logic rst4 = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    op_t  c2 = '0;
    op_t  c4 = '0;
    out_t o2, o4;
    bit [31:0] m2 [256];
    bit [31:0] m4 [256];

    always #5 clk = ~clk;

    mem_access_stage_if i2 ();
    mem_access_stage_if i4 ();

    mem_access_stage #(.ADDR_W(8), .MEM_LAT(2)) u2 (
        .clk (clk), .rst (rst2), .bus (i2.slave)
    );
    mem_access_stage #(.ADDR_W(8), .MEM_LAT(4)) u4 (
        .clk (clk), .rst (rst4), .bus (i4.slave)
    );

    assign i2.in_valid = c2.v;     assign i4.in_valid = c4.v;
    assign i2.memRead = c2.rd;     assign i4.memRead = c4.rd;
    assign i2.memWrite = c2.wr;    assign i4.memWrite = c4.wr;
    assign i2.branch = c2.br;      assign i4.branch = c4.br;
    assign i2.regWrite = c2.rw;    assign i4.regWrite = c4.rw;
    assign i2.memToReg = c2.m2r;   assign i4.memToReg = c4.m2r;
    assign i2.aluZero = c2.z;      assign i4.aluZero = c4.z;
    assign i2.alures = c2.alu;     assign i4.alures = c4.alu;
    assign i2.readData2 = c2.wd;   assign i4.readData2 = c4.wd;
    assign i2.addres = c2.tgt;     assign i4.addres = c4.tgt;
    assign i2.instruction = c2.dst; assign i4.instruction = c4.dst;

    assign o2 = {i2.stall, i2.pcSrc, i2.branchTarget, i2.wb_valid,
                 i2.wb_regWrite, i2.wb_memToReg, i2.wb_readData,
                 i2.wb_aluResult, i2.wb_writeReg, i2.misaligned};
    assign o4 = {i4.stall, i4.pcSrc, i4.branchTarget, i4.wb_valid,
                 i4.wb_regWrite, i4.wb_memToReg, i4.wb_readData,
                 i4.wb_aluResult, i4.wb_writeReg, i4.misaligned};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic op_t mk(input bit rd, input bit wr, input bit br,
                               input bit z, input bit [31:0] alu,
                               input bit [31:0] wd, input bit [31:0] tgt,
                               input bit [4:0] dst);
        op_t o;
        o = '0;
        o.v = 1'b1; o.rd = rd; o.wr = wr; o.br = br; o.z = z;
        o.rw = rd | ~wr; o.m2r = rd; o.alu = alu; o.wd = wd;
        o.tgt = tgt; o.dst = dst;
        return o;
    endfunction

    // Model: latency is MEM_LAT for memory ops and 1 otherwise; stall is
    // high in every held cycle except the last; memory is a plain array.
    task automatic run_op(input bit big, input op_t o);
        int n;
        int idx;
        bit mop, mis, ld;
        logic [31:0] er;
        out_t ob;
        mop = o.rd | o.wr;
        n   = mop ? (big ? 4 : 2) : 1;
        mis = mop && (o.alu[1:0] != 2'b00);
        idx = int'(o.alu[9:2]);
        ld  = o.rd && !o.wr && !mis;
        er  = ld ? (big ? m4[idx] : m2[idx]) : 32'h0;
        if (o.wr && !mis) begin
            if (big) m4[idx] = o.wd;
            else m2[idx] = o.wd;
        end
        if (big) c4 = o;
        else c2 = o;
        #1;
        for (int i = 0; i < n; i++) begin
            ob = big ? o4 : o2;
            chk("stall", ob.stall, 32'((i < n - 1) && mop));
            @(negedge clk);
        end
        ob = big ? o4 : o2;
        chk("wb_valid", ob.v, 1);
        chk("wb_regWrite", ob.rw, o.rw);
        chk("wb_memToReg", ob.m2r, o.m2r);
        chk("wb_aluResult", ob.alu, o.alu);
        chk("wb_writeReg", ob.wr, o.dst);
        chk("pcSrc", ob.pc, o.br & o.z);
        chk("branchTarget", ob.tgt, o.tgt);
        chk("misaligned", ob.mis, mis);
        if (o.rd || mis) chk("wb_readData", ob.rdat, er);
        if (big) c4.v = 1'b0;
        else c2.v = 1'b0;
    endtask

    task automatic idle_chk(input bit big, input logic [31:0] last_alu);
        out_t ob;
        @(negedge clk);
        ob = big ? o4 : o2;
        chk("idle_wb_valid", ob.v, 0);
        chk("idle_pcSrc", ob.pc, 0);
        chk("idle_misaligned", ob.mis, 0);
        chk("idle_hold_alu", ob.alu, last_alu);
    endtask

    initial begin
        op_t o;
        int k, widx;
        bit [31:0] a;
        repeat (2) @(negedge clk);
        chk("rst_wb_valid", o2.v, 0);
        chk("rst_pcSrc", o2.pc, 0);
        chk("rst_alu", o2.alu, 0);
        chk("rst_tgt", o2.tgt, 0);
        chk("rst_stall", o2.stall, 0);
        chk("rst4_wb_valid", o4.v, 0);
        rst2 = 1'b0;
        rst4 = 1'b0;
        @(negedge clk);

        run_op(0, mk(0, 1, 0, 0, 32'h10, 32'hDEADBEEF, 32'h0, 5'd3));
        run_op(0, mk(1, 0, 0, 0, 32'h10, 32'h0, 32'h0, 5'd9));
        idle_chk(0, 32'h10);
        run_op(0, mk(0, 0, 0, 0, 32'h7, 32'h0, 32'h0, 5'd5));
        idle_chk(0, 32'h7);
        run_op(0, mk(0, 0, 1, 1, 32'h0, 32'h0, 32'h40, 5'd0));
        run_op(0, mk(0, 0, 1, 0, 32'h1, 32'h0, 32'h40, 5'd0));
        run_op(0, mk(0, 1, 0, 0, 32'h13, 32'h12345678, 32'h0, 5'd1));
        run_op(0, mk(1, 0, 0, 0, 32'h10, 32'h0, 32'h0, 5'd2));
        run_op(0, mk(1, 0, 0, 0, 32'h11, 32'h0, 32'h0, 5'd4));
        run_op(0, mk(0, 1, 0, 0, 32'h400, 32'hCAFEF00D, 32'h0, 5'd6));
        run_op(0, mk(1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd7));
        run_op(0, mk(1, 1, 0, 0, 32'h14, 32'hA5A5A5A5, 32'h0, 5'd8));
        run_op(0, mk(1, 0, 0, 0, 32'h14, 32'h0, 32'h0, 5'd8));

        for (int i = 0; i < 16; i++) begin
            a = ($urandom & 32'hFFFF_FC00) | 32'(i << 2);
            run_op(0, mk(0, 1, 0, 0, a, $urandom, $urandom, 5'(i)));
        end
        for (int i = 0; i < 80; i++) begin
            k    = $urandom_range(0, 3);
            widx = $urandom_range(0, 15);
            a = ($urandom & 32'hFFFF_FC00) | 32'(widx << 2);
            if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
            o = mk(k == 1 || k == 3, k >= 2, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 1) == 1, a, $urandom, $urandom,
                   5'($urandom));
            run_op(0, o);
            if ($urandom_range(0, 3) == 0) idle_chk(0, a);
        end

        run_op(1, mk(0, 0, 0, 0, 32'h3, 32'h0, 32'h0, 5'd5));
        run_op(1, mk(0, 1, 1, 1, 32'h20, 32'h11111111, 32'h80, 5'd7));
        c4 = mk(0, 1, 1, 1, 32'h20, 32'h22222222, 32'h90, 5'd9);
        #1;
        chk("abort_stall0", o4.stall, 1);
        @(negedge clk);
        chk("abort_stall1", o4.stall, 1);
        rst4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;
        c4.v = 1'b0;
        #1;
        chk("abort_wb_valid", o4.v, 0);
        chk("abort_pcSrc", o4.pc, 0);
        chk("abort_tgt", o4.tgt, 0);
        chk("abort_alu", o4.alu, 0);
        chk("abort_wr", o4.wr, 0);
        chk("abort_rw", o4.rw, 0);
        chk("abort_stall", o4.stall, 0);
        @(negedge clk);
        run_op(1, mk(1, 0, 0, 0, 32'h20, 32'h0, 32'h0, 5'd11));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
